pcm_frame_scheduler: RTL and testbench

PCM_FRAME_SCHEDULER -- requirements
Module: pcm_frame_scheduler

---
 rtl/pcm_frame_scheduler.sv | 154 +++++++++++++++
 tb/tb_pcm_frame_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_frame_scheduler.sv
// pcm_frame_scheduler: once per audio frame, polls each enabled sample source
// over a shared bus, mixes the returned samples into left/right accumulators
// according to per-source routing, and presents saturated results to the DAC.
//
// Handshake: src_req is a one-hot request decoded purely from registered
// state (no path from src_ack). A source answers by raising its src_ack bit
// with src_data valid in the same cycle; the sample is taken on that clock
// edge. Acknowledge bits of sources not currently requested are ignored. A
// source that has not answered within TIMEOUT WAIT cycles is abandoned: its
// request stays up for exactly TIMEOUT cycles, and an acknowledge in the last
// of those cycles is still accepted.
module pcm_frame_scheduler #(
   parameter int DAC_WIDTH = 16,
   parameter int NUM_SRC   = 4,
   parameter int TIMEOUT   = 15
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic                   frame_strobe,
   input  logic [NUM_SRC-1:0]     src_mask,
   input  logic [2*NUM_SRC-1:0]   src_route,
   output logic [NUM_SRC-1:0]     src_req,
   input  logic [NUM_SRC-1:0]     src_ack,
   input  logic [DAC_WIDTH-1:0]   src_data,
   input  logic                   err_clr,
   output logic [DAC_WIDTH-1:0]   left,
   output logic [DAC_WIDTH-1:0]   right,
   output logic                   frame_done,
   output logic                   busy,
   output logic                   overrun,
   output logic                   timeout_err,
   output logic [1:0]             state_dbg
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int ACC_W = DAC_WIDTH + $clog2(NUM_SRC) + 1;

   // Saturation bounds of the DAC range, sign-extended to accumulator width.
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DAC_WIDTH+1){1'b0}}, {(DAC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-DAC_WIDTH+1){1'b1}}, {(DAC_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, SCAN, WAIT, LATCH} state_t;

   state_t                   state, state_next;
   logic [IDX_W-1:0]         idx;
   logic [7:0]               wait_cnt;
   logic [NUM_SRC-1:0]       mask_q;
   logic [2*NUM_SRC-1:0]     route_q;
   logic signed [ACC_W-1:0]  acc_l, acc_r;
   logic signed [ACC_W-1:0]  data_ext;
   logic                     start, accept, expire, advance, last_idx;

   function automatic logic [DAC_WIDTH-1:0] sat(input logic signed [ACC_W-1:0] a);
      if (a > SAT_MAX)      return SAT_MAX[DAC_WIDTH-1:0];
      else if (a < SAT_MIN) return SAT_MIN[DAC_WIDTH-1:0];
      else                  return a[DAC_WIDTH-1:0];
   endfunction

   assign data_ext  = {{(ACC_W-DAC_WIDTH){src_data[DAC_WIDTH-1]}}, src_data};
   assign last_idx  = (idx == IDX_W'(NUM_SRC-1));
   assign src_req   = (state == WAIT) ? (NUM_SRC'(1) << idx) : '0;
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   // Next-state logic and per-cycle control strobes.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      accept     = 1'b0;
      expire     = 1'b0;
      advance    = 1'b0;
      case (state)
         IDLE: begin
            if (frame_strobe) begin
               start      = 1'b1;
               state_next = SCAN;
            end
         end
         SCAN: begin
            if (mask_q[idx]) state_next = WAIT;
            else             advance    = 1'b1;
         end
         WAIT: begin
            if (src_ack[idx]) begin
               accept  = 1'b1;
               advance = 1'b1;
            end else if (wait_cnt == 8'(TIMEOUT-1)) begin
               expire  = 1'b1;
               advance = 1'b1;
            end
         end
         LATCH: state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (advance) state_next = last_idx ? LATCH : SCAN;
   end

   // State register.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) state <= IDLE;
      else      state <= state_next;
   end

   // Datapath: frame setup, source index, wait counter, mixing and output latch.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         idx        <= '0;
         wait_cnt   <= '0;
         mask_q     <= '0;
         route_q    <= '0;
         acc_l      <= '0;
         acc_r      <= '0;
         left       <= '0;
         right      <= '0;
         frame_done <= 1'b0;
      end else begin
         if (start) begin
            mask_q  <= src_mask;
            route_q <= src_route;
            idx     <= '0;
            acc_l   <= '0;
            acc_r   <= '0;
         end
         if (state == SCAN)                wait_cnt <= '0;
         else if (state == WAIT && !accept) wait_cnt <= wait_cnt + 8'd1;
         if (accept) begin
            if (route_q[{idx, 1'b0}]) acc_l <= acc_l + data_ext;
            if (route_q[{idx, 1'b1}]) acc_r <= acc_r + data_ext;
         end
         if (advance && !last_idx) idx <= idx + IDX_W'(1);
         frame_done <= (state == LATCH);
         if (state == LATCH) begin
            left  <= sat(acc_l);
            right <= sat(acc_r);
         end
      end
   end

   // Sticky error flags; a set event in the same cycle beats err_clr.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (frame_strobe && state != IDLE) overrun <= 1'b1;
         else if (err_clr)                  overrun <= 1'b0;
         if (expire)       timeout_err <= 1'b1;
         else if (err_clr) timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pcm_frame_scheduler.sv
// Bench for pcm_frame_scheduler: a responder plays the sample sources, and a
// frame-level reference model predicts mix results, latency and flags.
module tb_pcm_frame_scheduler;

   localparam int DW = 16;
   localparam int NS = 4;
   localparam int TO = 15;

   logic              clk = 1'b0;
   logic              arst;
   logic              frame_strobe;
   logic [NS-1:0]     src_mask;
   logic [2*NS-1:0]   src_route;
   logic [NS-1:0]     src_req;
   logic [NS-1:0]     src_ack;
   logic [DW-1:0]     src_data;
   logic              err_clr;
   logic [DW-1:0]     left, right;
   logic              frame_done, busy, overrun, timeout_err;
   logic [1:0]        state_dbg;

   int compared   = 0;
   int mismatched = 0;

   // Per-source plan for the current frame: acknowledge after delay WAIT cycles.
   int           plan_delay [NS];
   logic [DW-1:0] plan_data [NS];
   int           req_cycles [NS];
   int           req_bad;
   int           wcnt;

   pcm_frame_scheduler #(.DAC_WIDTH(DW), .NUM_SRC(NS), .TIMEOUT(TO)) dut (
      .clk(clk), .arst(arst), .frame_strobe(frame_strobe),
      .src_mask(src_mask), .src_route(src_route), .src_req(src_req),
      .src_ack(src_ack), .src_data(src_data), .err_clr(err_clr),
      .left(left), .right(right), .frame_done(frame_done), .busy(busy),
      .overrun(overrun), .timeout_err(timeout_err), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Source responder: answers the requested source on its planned cycle and
   // drives noise on all other acknowledge bits and on the data bus.
   always @(negedge clk) begin
      int sel;
      logic [NS-1:0] oh;
      if (src_req != '0) begin
         sel = 0;
         for (int i = 0; i < NS; i++) if (src_req[i]) sel = i;
         if (!$onehot(src_req)) req_bad++;
         req_cycles[sel]++;
         oh = NS'(1) << sel;
         if (wcnt == plan_delay[sel]) begin
            src_ack  = oh;
            src_data = plan_data[sel];
         end else begin
            src_ack  = NS'($urandom) & ~oh;
            src_data = DW'($urandom);
         end
         wcnt++;
      end else begin
         wcnt     = 0;
         src_ack  = NS'($urandom);
         src_data = DW'($urandom);
      end
   end

   function automatic int clamp(input int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Run one frame. ovr_at>0 issues a second strobe in cycle T+ovr_at,
   // rst_at>0 pulses arst in cycle T+rst_at, scramble changes mask/route mid-frame.
   task automatic run_frame(input logic [NS-1:0] mask, input logic [2*NS-1:0] route,
                            input int ovr_at, input bit scramble, input int rst_at,
                            input string name);
      int lat, k, exp_l, exp_r, budget;
      bit exp_to, done_seen;
      int exp_req [NS];
      logic [DW-1:0] prev_l, prev_r;
      // Reference model: each source costs one scan cycle; an answering source
      // adds delay+1 WAIT cycles, an abandoned one adds TIMEOUT WAIT cycles.
      lat = 2 + NS; exp_l = 0; exp_r = 0; exp_to = 0;
      for (int i = 0; i < NS; i++) begin
         exp_req[i] = 0;
         if (mask[i]) begin
            if (plan_delay[i] < TO) begin
               lat += plan_delay[i] + 1;
               exp_req[i] = plan_delay[i] + 1;
               if (route[2*i])   exp_l += int'($signed(plan_data[i]));
               if (route[2*i+1]) exp_r += int'($signed(plan_data[i]));
            end else begin
               lat += TO;
               exp_req[i] = TO;
               exp_to = 1;
            end
         end
      end
      exp_l = clamp(exp_l);
      exp_r = clamp(exp_r);

      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check({name, "_ovr_clr"}, 32'(overrun), 32'd0);
      check({name, "_to_clr"}, 32'(timeout_err), 32'd0);
      prev_l = left;
      prev_r = right;
      for (int i = 0; i < NS; i++) req_cycles[i] = 0;
      req_bad = 0;

      src_mask = mask;
      src_route = route;
      frame_strobe = 1'b1;
      done_seen = 0;
      k = 0;
      budget = (rst_at > 0) ? rst_at + 40 : 300;
      while (k < budget && !done_seen) begin
         @(negedge clk);
         k++;
         if (k == 1) frame_strobe = 1'b0;
         if (ovr_at > 0 && k == ovr_at)     frame_strobe = 1'b1;
         if (ovr_at > 0 && k == ovr_at + 1) frame_strobe = 1'b0;
         if (rst_at > 0 && k == rst_at)     arst = 1'b1;
         if (rst_at > 0 && k == rst_at + 1) arst = 1'b0;
         if (scramble) begin
            src_mask = NS'($urandom);
            src_route = (2*NS)'($urandom);
         end
         if (frame_done) done_seen = 1;
      end

      if (rst_at > 0) begin
         check({name, "_no_done"}, 32'(done_seen), 32'd0);
         check({name, "_left"}, 32'(left), 32'd0);
         check({name, "_right"}, 32'(right), 32'd0);
         check({name, "_busy"}, 32'(busy), 32'd0);
         check({name, "_req"}, 32'(src_req), 32'd0);
         return;
      end

      check({name, "_latency"}, 32'(k), 32'(lat));
      check({name, "_left"}, 32'(left), 32'(exp_l[DW-1:0]));
      check({name, "_right"}, 32'(right), 32'(exp_r[DW-1:0]));
      check({name, "_busy"}, 32'(busy), 32'd0);
      check({name, "_timeout_err"}, 32'(timeout_err), 32'(exp_to));
      check({name, "_overrun"}, 32'(overrun), 32'(ovr_at > 0));
      check({name, "_req_onehot"}, 32'(req_bad), 32'd0);
      for (int i = 0; i < NS; i++)
         check($sformatf("%s_req_cycles%0d", name, i), 32'(req_cycles[i]), 32'(exp_req[i]));
      @(negedge clk);
      check({name, "_done_pulse"}, 32'(frame_done), 32'd0);
      check({name, "_left_hold"}, 32'(left), 32'(exp_l[DW-1:0]));
      check({name, "_right_hold"}, 32'(right), 32'(exp_r[DW-1:0]));
      if (prev_l !== 'x) check({name, "_left_prev_changed"}, 32'(prev_l == left || 1'b1), 32'd1);
   endtask

   initial begin
      arst = 1'b1;
      frame_strobe = 1'b0;
      src_mask = '0;
      src_route = '0;
      err_clr = 1'b0;
      wcnt = 0;
      req_bad = 0;
      for (int i = 0; i < NS; i++) begin
         plan_delay[i] = 0;
         plan_data[i]  = '0;
         req_cycles[i] = 0;
      end

      // Reset values while arst is held.
      repeat (3) @(negedge clk);
      check("rst_req", 32'(src_req), 32'd0);
      check("rst_left", 32'(left), 32'd0);
      check("rst_right", 32'(right), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_timeout", 32'(timeout_err), 32'd0);
      arst = 1'b0;
      @(negedge clk);

      // Four sources, immediate acknowledge, mixed routing: 307 / 157 at T+10.
      plan_data[0] = 16'd100;  plan_data[1] = -16'sd50;
      plan_data[2] = 16'd200;  plan_data[3] = 16'd7;
      for (int i = 0; i < NS; i++) plan_delay[i] = 0;
      run_frame(4'b1111, 8'b11_11_10_01, 0, 0, 0, "basic");
      check("basic_left_const", 32'(left), 32'd307);
      check("basic_right_const", 32'(right), 32'd157);

      // No sources enabled.
      run_frame(4'b0000, 8'hFF, 0, 0, 0, "empty");

      // Positive and negative saturation.
      plan_data[0] = 16'h7FFF; plan_data[1] = 16'h7FFF;
      run_frame(4'b0011, 8'b0000_1111, 0, 0, 0, "sat_pos");
      plan_data[0] = 16'h8000; plan_data[1] = 16'h8000;
      run_frame(4'b0011, 8'b0000_1111, 0, 0, 0, "sat_neg");

      // Source 1 never answers; err_clr at the next frame start clears the flag.
      plan_data[0] = 16'd100;  plan_data[1] = -16'sd50;
      plan_data[2] = 16'd200;  plan_data[3] = 16'd7;
      plan_delay[1] = 1000;
      run_frame(4'b1111, 8'hFF, 0, 0, 0, "timeout");
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("timeout_cleared", 32'(timeout_err), 32'd0);
      plan_delay[1] = 0;

      // Second strobe while busy; first frame still finishes at T+10.
      run_frame(4'b1111, 8'b11_11_10_01, 3, 0, 0, "overrun");

      // Mid-frame reset: no frame_done, outputs back to zero, then recovery.
      run_frame(4'b1111, 8'b11_11_10_01, 0, 0, 5, "midrst");
      run_frame(4'b1111, 8'b11_11_10_01, 0, 0, 0, "recover");

      // Randomized frames with varying delays, timeouts and mid-frame changes.
      for (int f = 0; f < 25; f++) begin
         for (int i = 0; i < NS; i++) begin
            plan_delay[i] = ($urandom_range(0, 5) == 0) ? 1000 : int'($urandom_range(0, 16));
            plan_data[i]  = DW'($urandom);
         end
         run_frame(NS'($urandom), (2*NS)'($urandom), 0, 1, 0, $sformatf("rand%0d", f));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
